// File: rtl/alu.sv
// Multi-cycle 8-bit 6502-style ALU: IDLE -> EXEC -> [ADJUST] -> DONE.
// Define DECIMAL_MODE_EN to build in the BCD ADJUST state for ADC/SBC with D=1.
module alu (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic [7:0] data_in_status,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic [7:0] data_out_status
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_ADJUST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_BIT = 4'd12;
  localparam logic [3:0] OP_PAS = 4'd13;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_p;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_data_out;
  logic [7:0] r_data_out_status;
  logic       w_dec;
  logic [7:0] w_bop;
  logic [8:0] w_sum;
  logic [8:0] w_cmp;
  logic [7:0] w_res;
  logic [7:0] w_st;
  logic       w_zn;

  assign busy            = r_busy;
  assign done            = r_done;
  assign data_out        = r_data_out;
  assign data_out_status = r_data_out_status;

`ifdef DECIMAL_MODE_EN
  logic [4:0] w_lo;
  logic [7:0] r_res;
  logic [7:0] r_stat;
  logic       r_half;
  logic [8:0] w_t;
  logic       w_c;
  logic [7:0] w_adj_res;
  logic [7:0] w_adj_st;

  assign w_dec = r_p[3] && ((r_op == OP_ADC) || (r_op == OP_SBC));
`else
  assign w_dec = 1'b0;
`endif

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_EXEC;
        else       w_next = S_IDLE;
      end
      S_EXEC: begin
        if (w_dec) w_next = S_ADJUST;
        else       w_next = S_DONE;
      end
`ifdef DECIMAL_MODE_EN
      S_ADJUST: w_next = S_DONE;
`endif
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register plus busy/done, registered from the next state.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Binary result and flags from the latched operands.
  always_comb begin
    w_bop = (r_op == OP_SBC) ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bop} + {8'd0, r_p[0]};
    w_cmp = {1'b0, r_a} - {1'b0, r_b};
    w_res = r_a;
    w_st  = r_p;
    w_zn  = 1'b1;
    case (r_op)
      OP_ADC, OP_SBC: begin
        w_res   = w_sum[7:0];
        w_st[0] = w_sum[8];
        w_st[6] = (r_a[7] == w_bop[7]) && (w_sum[7] != r_a[7]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_ORA: w_res = r_a | r_b;
      OP_EOR: w_res = r_a ^ r_b;
      OP_ASL: begin
        w_res   = {r_a[6:0], 1'b0};
        w_st[0] = r_a[7];
      end
      OP_LSR: begin
        w_res   = {1'b0, r_a[7:1]};
        w_st[0] = r_a[0];
      end
      OP_ROL: begin
        w_res   = {r_a[6:0], r_p[0]};
        w_st[0] = r_a[7];
      end
      OP_ROR: begin
        w_res   = {r_p[0], r_a[7:1]};
        w_st[0] = r_a[0];
      end
      OP_INC: w_res = r_a + 8'd1;
      OP_DEC: w_res = r_a - 8'd1;
      OP_CMP: begin
        w_zn    = 1'b0;
        w_st[0] = ~w_cmp[8];
        w_st[1] = (w_cmp[7:0] == 8'h00);
        w_st[7] = w_cmp[7];
      end
      OP_BIT: begin
        w_zn    = 1'b0;
        w_st[1] = ((r_a & r_b) == 8'h00);
        w_st[6] = r_b[6];
        w_st[7] = r_b[7];
      end
      OP_PAS: w_res = r_a;
      default: w_zn = 1'b0;
    endcase
    if (w_zn) begin
      w_st[1] = (w_res == 8'h00);
      w_st[7] = w_res[7];
    end else begin
      w_st = w_st;
    end
  end

`ifdef DECIMAL_MODE_EN
  // Half-carry of the low nibble; for SBC a clear half-carry means a low-digit borrow.
  assign w_lo = {1'b0, r_a[3:0]} + {1'b0, w_bop[3:0]} + {4'd0, r_p[0]};

  // BCD correction of the EXEC result; V keeps its binary value.
  always_comb begin
    w_t      = {1'b0, r_res};
    w_c      = r_stat[0];
    w_adj_st = r_stat;
    if (r_op == OP_ADC) begin
      if ((r_res[3:0] > 4'd9) || r_half) w_t = w_t + 9'h006;
      else                               w_t = w_t;
      if ((w_t[7:4] > 4'd9) || w_c || w_t[8]) begin
        w_t = w_t + 9'h060;
        w_c = 1'b1;
      end else begin
        w_c = w_c;
      end
    end else begin
      if (!r_half)    w_t = w_t - 9'h006;
      else            w_t = w_t;
      if (!r_stat[0]) w_t = w_t - 9'h060;
      else            w_t = w_t;
    end
    w_adj_res   = w_t[7:0];
    w_adj_st[0] = w_c;
    w_adj_st[1] = (w_adj_res == 8'h00);
    w_adj_st[7] = w_adj_res[7];
  end
`endif

  // Operand latch on accept and result/status output registers.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_op              <= 4'd0;
      r_a               <= 8'h00;
      r_b               <= 8'h00;
      r_p               <= 8'h00;
      r_data_out        <= 8'h00;
      r_data_out_status <= 8'h00;
`ifdef DECIMAL_MODE_EN
      r_res             <= 8'h00;
      r_stat            <= 8'h00;
      r_half            <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= operand_a;
            r_b  <= operand_b;
            r_p  <= data_in_status;
          end
        end
        S_EXEC: begin
`ifdef DECIMAL_MODE_EN
          r_res  <= w_res;
          r_stat <= w_st;
          r_half <= w_lo[4];
`endif
          if (!w_dec) begin
            r_data_out        <= w_res;
            r_data_out_status <= w_st;
          end
        end
`ifdef DECIMAL_MODE_EN
        S_ADJUST: begin
          r_data_out        <= w_adj_res;
          r_data_out_status <= w_adj_st;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expectations follow DECIMAL_MODE_EN when defined.
module tb_alu;

  logic       clk_1;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] data_in_status;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic [7:0] data_out_status;

  int n_checks = 0;
  int n_pass   = 0;

  alu dut (
    .clk_1           (clk_1),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .data_in_status  (data_in_status),
    .busy            (busy),
    .done            (done),
    .data_out        (data_out),
    .data_out_status (data_out_status)
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one op from IDLE and check result, status, done cycle and pulse width.
  task automatic do_vec(input string tag, input logic [3:0] v_op, input logic [7:0] v_a,
                        input logic [7:0] v_b, input logic [7:0] v_p,
                        input logic [7:0] exp_res, input logic [7:0] exp_st, input int exp_cyc);
    int cyc;
    @(negedge clk_1);
    op = v_op; operand_a = v_a; operand_b = v_b; data_in_status = v_p; start = 1'b1;
    @(posedge clk_1); #1;
    start = 1'b0;
    cyc = 1;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 8) begin
      @(posedge clk_1); #1;
      cyc++;
    end
    check_eq({tag, "_cyc"}, cyc, exp_cyc);
    check_eq({tag, "_res"}, {24'd0, data_out}, {24'd0, exp_res});
    check_eq({tag, "_st"}, {24'd0, data_out_status}, {24'd0, exp_st});
    @(posedge clk_1); #1;
    check_eq({tag, "_done_drop"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [7:0] seen [0:3];
    rst = 1'b1; start = 1'b0; op = 4'd0;
    operand_a = 8'h00; operand_b = 8'h00; data_in_status = 8'h00;
    repeat (3) @(posedge clk_1);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_out", {24'd0, data_out}, 32'd0);
    check_eq("rst_st", {24'd0, data_out_status}, 32'd0);
    rst = 1'b0;

    do_vec("adc_bin", 4'd0,  8'h50, 8'h50, 8'h00, 8'hA0, 8'hC0, 2);
    do_vec("sbc",     4'd1,  8'h00, 8'h01, 8'h01, 8'hFF, 8'h80, 2);
    do_vec("cmp",     4'd11, 8'h40, 8'h40, 8'h00, 8'h40, 8'h03, 2);
    do_vec("ror",     4'd8,  8'h01, 8'h00, 8'h01, 8'h80, 8'h81, 2);
    do_vec("bit",     4'd12, 8'h0F, 8'hC0, 8'h00, 8'h0F, 8'hC2, 2);
    do_vec("and_idb", 4'd2,  8'hF0, 8'h0F, 8'h34, 8'h00, 8'h36, 2);
    do_vec("inc_wrap",4'd9,  8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 2);
    do_vec("dec_wrap",4'd10, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80, 2);
    do_vec("lsr",     4'd6,  8'h81, 8'h00, 8'h80, 8'h40, 8'h01, 2);
    do_vec("rsvd",    4'd14, 8'h33, 8'h77, 8'hA5, 8'h33, 8'hA5, 2);
    do_vec("adc_i",   4'd0,  8'h01, 8'h01, 8'h04, 8'h02, 8'h04, 2);
`ifdef DECIMAL_MODE_EN
    do_vec("dadc1", 4'd0, 8'h58, 8'h46, 8'h09, 8'h05, 8'h49, 3);
    do_vec("dadc2", 4'd0, 8'h99, 8'h01, 8'h08, 8'h00, 8'h0B, 3);
    do_vec("dsbc",  4'd1, 8'h12, 8'h21, 8'h09, 8'h91, 8'h88, 3);
`else
    do_vec("dadc1", 4'd0, 8'h58, 8'h46, 8'h09, 8'h9F, 8'hC8, 2);
    do_vec("dadc2", 4'd0, 8'h99, 8'h01, 8'h08, 8'h9A, 8'h88, 2);
    do_vec("dsbc",  4'd1, 8'h12, 8'h21, 8'h09, 8'hF1, 8'h88, 2);
`endif

    // Reset while in EXEC: outputs clear, no done pulse afterwards.
    @(negedge clk_1);
    op = 4'd0; operand_a = 8'h01; operand_b = 8'h01; data_in_status = 8'h00; start = 1'b1;
    @(posedge clk_1); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk_1); #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_out", {24'd0, data_out}, 32'd0);
    check_eq("midrst_st", {24'd0, data_out_status}, 32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (4) begin
      @(posedge clk_1); #1;
      if (done) dones++;
    end
    check_eq("midrst_nodone", dones, 0);

    // Start held high every cycle with a changing operand: only IDLE-cycle starts count.
    dones = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_1);
      op = 4'd9; operand_b = 8'h00; data_in_status = 8'h00;
      operand_a = 8'(k); start = 1'b1;
      @(posedge clk_1); #1;
      if (k == 2) check_eq("hs_idle_busy", {31'd0, busy}, 32'd0);
      if (done) begin
        if (dones < 4) seen[dones] = data_out;
        dones++;
      end
    end
    @(negedge clk_1);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk_1); #1;
      if (done) dones++;
    end
    check_eq("hs_dones", dones, 3);
    check_eq("hs_op0", {24'd0, seen[0]}, 32'h01);
    check_eq("hs_op1", {24'd0, seen[1]}, 32'h04);
    check_eq("hs_op2", {24'd0, seen[2]}, 32'h07);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Multi-cycle 8-bit arithmetic/logic unit sitting directly upstream of the register file. It takes operands plus the current processor status, computes one 6502-style operation, and presents the result and the updated status byte. The controller writes them back through the register file's data_in and data_in_status on the cycle done is high. Decimal-mode ADC/SBC take one extra cycle for BCD adjust.

## Interface
- Parameters: none; all datapaths are fixed at 8 bits.
- clk_1  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- op  in  4  operation code, latched on accept.
- operand_a  in  8  first operand (A/X/Y/memory), latched on accept.
- operand_b  in  8  second operand, latched on accept.
- data_in_status  in  8  current P byte (C=0 Z=1 I=2 D=3 B=4 bit5 V=6 N=7), latched on accept.
- busy  out  1  high from the cycle after accept until done inclusive.
- done  out  1  one-cycle pulse; data_out/data_out_status valid.
- data_out  out  8  result; feeds register file data_in.
- data_out_status  out  8  updated P; feeds register file data_in_status.

## Operation
- Op codes:
  - 0 ADC: a+b+C.
  - 1 SBC: a+~b+C.
  - 2 AND; 3 ORA; 4 EOR.
  - 5 ASL a; 6 LSR a; 7 ROL a; 8 ROR a (rotates through C).
  - 9 INC a; 10 DEC a.
  - 11 CMP: a−b.
  - 12 BIT.
  - 13 PASS: result=a.
  - 14–15 reserved.
- Flags updated (all others copied from latched status):
  - ADC/SBC: C, Z, V, N.
  - Logic ops and PASS: Z, N.
  - Shifts: C = bit shifted out; Z, N.
  - INC/DEC: Z, N; wrap 0xFF↔0x00.
  - CMP: data_out=a; C = (a≥b unsigned); Z, N from (a−b)[7:0].
  - BIT: data_out=a; Z = ((a&b)==0); N = b[7]; V = b[6].
  - Reserved: data_out=a; status unchanged; done still pulses.
- Arithmetic rules:
  - 9-bit sum; C = bit 8.
  - V = (a[7]==b'[7]) && (sum[7]!=a[7]), where b' = b for ADC and ~b for SBC.
- I, D, B and bit 5 are never modified by any op.
- State machine IDLE → EXEC → [ADJUST] → DONE → IDLE:
  - IDLE: start=1 latches all inputs and moves to EXEC; start=0 stays in IDLE.
  - EXEC: computes the binary result and flags into internal registers. Goes to ADJUST if op∈{ADC,SBC} and latched D=1 (decimal build only), else DONE.
  - ADJUST: BCD correction.
    - ADC: low nibble >9 or half-carry → +0x06; then high >9 or carry → +0x60, C=1.
    - SBC: low borrow → −0x06; high borrow → −0x60; C = no borrow.
    - Z, N recomputed from the corrected result; V keeps its EXEC value.
    - Non-BCD operand digits give an undefined result (must not hang).
  - DONE: drives done=1 for one cycle, then returns to IDLE.
- start while busy=1 is ignored, not queued.
- data_out and data_out_status hold their last values until the next DONE.

## Timing
- Accept at edge N: busy=1 from cycle N+1.
- Binary: done=1 in cycle N+2.
- Decimal: done=1 in cycle N+3.
- busy falls with done; a new start is accepted in the cycle after done, giving back-to-back throughput of 1 op per 3 cycles (binary).
- Reset values: state=IDLE, busy=0, done=0, data_out=0x00, data_out_status=0x00.
- rst mid-operation: the in-flight op is discarded, there is no done pulse, and outputs return to reset values on that edge.
- rst and start in the same cycle: rst wins and start is dropped.

## Configuration
- DECIMAL_MODE_EN defined: ADJUST state and BCD logic are present; D=1 selects decimal ADC/SBC.
- DECIMAL_MODE_EN undefined: ADJUST is removed; D is ignored for arithmetic (still passed through unchanged); ADC/SBC are always binary with 2-cycle latency.

## Test plan
- Reset: assert rst mid-EXEC → next cycle busy=0, done=0, data_out=0x00, data_out_status=0x00; no done pulse follows.
- Binary ADC: a=0x50, b=0x50, P=0x00 → done at N+2, data_out=0xA0, V=1, N=1, C=0, Z=0.
- SBC/CMP:
  - SBC a=0x00, b=0x01, C=1 → data_out=0xFF, C=0, N=1.
  - CMP a=0x40, b=0x40 → data_out=0x40, Z=1, C=1.
- Decimal (DECIMAL_MODE_EN, P=0x08):
  - ADC 0x58+0x46, C=1 → done at N+3, data_out=0x05, C=1.
  - ADC 0x99+0x01, C=0 → data_out=0x00, Z=1, C=1.
  - SBC 0x12−0x21, C=1 → data_out=0x91, C=0.
  - Same stimulus without the macro → binary results, done at N+2.
- Shifts/BIT:
  - ROR a=0x01, C=1 → data_out=0x80, C=1, N=1.
  - BIT a=0x0F, b=0xC0 → Z=1, N=1, V=1, data_out=0x0F.
  - I/D/B bits preserved in all cases.
- Handshake: pulse start every cycle during busy → exactly one done per accepted op; extra starts are ignored; the next op is accepted in the cycle after done.
